// File: rtl/demux1x3_stream.sv
// Registered 1-to-3 stream demultiplexer with a one-entry holding register per channel.
// Optional DEMUX_ERR_CNT_EN builds a saturating counter of words dropped for select 3.
module demux1x3_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              s1,
  input  logic              s0,
  output logic [DATA_W-1:0] y0,
  output logic [DATA_W-1:0] y1,
  output logic [DATA_W-1:0] y2,
  output logic [2:0]        y_valid,
  input  logic [2:0]        y_ready,
  output logic [CNT_W-1:0]  err_cnt
);

  logic [1:0]        w_sel;
  logic              w_xfer;
  logic [2:0]        w_load;
  logic [2:0]        r_vld;
  logic [DATA_W-1:0] r_data [3];

  assign w_sel = {s1, s0};

  // A channel can take a word when it is empty or is being drained this cycle.
  always_comb begin
    in_ready = 1'b1;
    case (w_sel)
      2'd0:    in_ready = !r_vld[0] || y_ready[0];
      2'd1:    in_ready = !r_vld[1] || y_ready[1];
      2'd2:    in_ready = !r_vld[2] || y_ready[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign w_xfer    = in_valid && in_ready;
  assign w_load[0] = w_xfer && (w_sel == 2'd0);
  assign w_load[1] = w_xfer && (w_sel == 2'd1);
  assign w_load[2] = w_xfer && (w_sel == 2'd2);

  // Load has priority over drain so a simultaneous drain+load replaces the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 0; k < 3; k++) r_data[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (w_load[k]) begin
          r_vld[k]  <= 1'b1;
          r_data[k] <= in_data;
        end else if (y_ready[k]) begin
          r_vld[k]  <= 1'b0;
        end
      end
    end
  end

  assign y0      = r_data[0];
  assign y1      = r_data[1];
  assign y2      = r_data[2];
  assign y_valid = r_vld;

`ifdef DEMUX_ERR_CNT_EN
  logic             w_drop;
  logic [CNT_W-1:0] r_err_cnt;

  assign w_drop = w_xfer && (w_sel == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_drop && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_demux1x3_stream.sv
// Randomized and directed bench for demux1x3_stream against a queue-based channel model.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_demux1x3_stream;
  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          s1, s0;
  logic [DW-1:0] y0, y1, y2;
  logic [2:0]    y_valid;
  logic [2:0]    y_ready;
  logic [CW-1:0] err_cnt;

  logic          st_valid, st_ready, st_s1, st_s0;
  logic [DW-1:0] st_data, st_y0, st_y1, st_y2;
  logic [2:0]    st_yvalid;
  logic [1:0]    st_err;

  always #5 clk = ~clk;

  demux1x3_stream #(.DATA_W(DW), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .s1(s1), .s0(s0), .y0(y0), .y1(y1), .y2(y2), .y_valid(y_valid), .y_ready(y_ready),
    .err_cnt(err_cnt)
  );

  demux1x3_stream #(.DATA_W(DW), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(st_valid), .in_ready(st_ready), .in_data(st_data),
    .s1(st_s1), .s0(st_s0), .y0(st_y0), .y1(st_y1), .y2(st_y2), .y_valid(st_yvalid),
    .y_ready(3'b111), .err_cnt(st_err)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_drop  = 0;
  logic [DW-1:0] chq [3][$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int err_exp(input int drops, input int cw);
`ifdef DEMUX_ERR_CNT_EN
    int lim;
    lim = (1 << cw) - 1;
    return (drops > lim) ? lim : drops;
`else
    return 0;
`endif
  endfunction

  function automatic logic [DW-1:0] ydat(input int k);
    case (k)
      0:       return y0;
      1:       return y1;
      default: return y2;
    endcase
  endfunction

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle, compare against the model, then advance the model past the edge.
  task automatic step(input logic iv, input logic [1:0] sel, input logic [DW-1:0] d,
                      input logic [2:0] yr, output logic acc);
    logic er;
    @(negedge clk);
    in_valid = iv;
    {s1, s0} = sel;
    in_data  = d;
    y_ready  = yr;
    #1;
    if (sel == 2'd3) er = 1'b1;
    else             er = (chq[sel].size() == 0) || yr[sel];
    chk("in_ready", 32'(in_ready), 32'(er));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("y_valid%0d", k), 32'(y_valid[k]), 32'(chq[k].size() != 0));
      if (chq[k].size() != 0) chk($sformatf("y%0d", k), 32'(ydat(k)), 32'(chq[k][0]));
    end
    chk("err_cnt", 32'(err_cnt), 32'(err_exp(n_drop, CW)));
    acc = iv && er;
    for (int k = 0; k < 3; k++)
      if (chq[k].size() != 0 && yr[k]) void'(chq[k].pop_front());
    if (acc) begin
      if (sel == 2'd3) n_drop++;
      else             chq[sel].push_back(d);
    end
  endtask

  initial begin
    logic          acc;
    logic          hold;
    logic          r_iv;
    logic [1:0]    r_sel;
    logic [DW-1:0] r_d;
    logic [2:0]    r_yr;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; {s1, s0} = 2'd0; y_ready = 3'b000;
    st_valid = 1'b0; st_data = '0; {st_s1, st_s0} = 2'd3;
    #1;
    chk("rst_y_valid", 32'(y_valid), 32'd0);
    chk("rst_y0", 32'(y0), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Route
    step(1'b1, 2'd0, 8'hA5, 3'b111, acc);
    step(1'b1, 2'd1, 8'h3C, 3'b111, acc);
    step(1'b1, 2'd2, 8'h81, 3'b111, acc);
    settle();
    chk("route_y2", 32'(y2), 32'h81);
    chk("route_vld", 32'(y_valid), 32'b100);
    step(1'b0, 2'd0, 8'h00, 3'b111, acc);

    // Backpressure on channel 1
    step(1'b1, 2'd1, 8'h11, 3'b101, acc);
    chk("bp_acc1", 32'(acc), 32'd1);
    settle();
    chk("bp_y1", 32'(y1), 32'h11);
    step(1'b1, 2'd1, 8'h22, 3'b101, acc);
    chk("bp_stall", 32'(acc), 32'd0);
    step(1'b1, 2'd1, 8'h22, 3'b101, acc);
    chk("bp_stall2", 32'(acc), 32'd0);
    chk("bp_hold", 32'(y1), 32'h11);
    step(1'b1, 2'd1, 8'h22, 3'b111, acc);
    chk("bp_release", 32'(acc), 32'd1);
    settle();
    chk("bp_y1_new", 32'(y1), 32'h22);

    // Isolation: y1 full and stalled
    step(1'b1, 2'd0, 8'h55, 3'b101, acc);
    chk("iso_acc0", 32'(acc), 32'd1);
    step(1'b1, 2'd2, 8'h66, 3'b101, acc);
    chk("iso_acc2", 32'(acc), 32'd1);
    settle();
    chk("iso_y2", 32'(y2), 32'h66);
    chk("iso_y1", 32'(y1), 32'h22);

    // Illegal select
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'd3, 8'(8'hE0 + i), 3'b101, acc);
      chk("ill_acc", 32'(acc), 32'd1);
    end
    settle();
    chk("ill_vld", 32'(y_valid), 32'b010);
`ifdef DEMUX_ERR_CNT_EN
    chk("ill_err", 32'(err_cnt), 32'd3);
`else
    chk("ill_err", 32'(err_cnt), 32'd0);
`endif

    // Saturation on the CNT_W=2 instance
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      st_valid = 1'b1; {st_s1, st_s0} = 2'd3; st_data = 8'(i);
      #1;
      chk("sat_ready", 32'(st_ready), 32'd1);
      chk("sat_cnt", 32'(st_err), 32'(err_exp(i, 2)));
    end
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    chk("sat_final", 32'(st_err), 32'(err_exp(5, 2)));
    chk("sat_vld", 32'(st_yvalid), 32'd0);

    // Randomized traffic; producer holds word and select while stalled
    hold = 1'b0; r_iv = 1'b0; r_sel = 2'd0; r_d = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        r_iv  = ($urandom % 4) != 0;
        r_sel = 2'($urandom % 4);
        r_d   = 8'($urandom);
      end
      r_yr = 3'($urandom);
      step(r_iv, r_sel, r_d, r_yr, acc);
      hold = r_iv && !acc;
    end

    // Asynchronous reset mid-stream with all channels full
    step(1'b0, 2'd0, 8'h00, 3'b111, acc);
    step(1'b1, 2'd0, 8'h01, 3'b000, acc);
    step(1'b1, 2'd1, 8'h02, 3'b000, acc);
    step(1'b1, 2'd2, 8'h03, 3'b000, acc);
    step(1'b1, 2'd3, 8'h04, 3'b000, acc);
    step(1'b0, 2'd0, 8'h00, 3'b000, acc);
    chk("pre_rst_vld", 32'(y_valid), 32'b111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_vld", 32'(y_valid), 32'd0);
    chk("async_y0", 32'(y0), 32'd0);
    chk("async_y1", 32'(y1), 32'd0);
    chk("async_y2", 32'(y2), 32'd0);
    chk("async_err", 32'(err_cnt), 32'd0);
    for (int k = 0; k < 3; k++) chq[k].delete();
    n_drop = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'd1, 8'h77, 3'b000, acc);
    step(1'b0, 2'd0, 8'h00, 3'b111, acc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
